mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 op  in  6  opcode from instruction register.
REQ-005 funct  in  6  R-type function field from instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory access completes this cycle.
REQ-008 pcen, irwrite, memwrite, regwrite  out  1 each  PC, IR, memory and register-file write enables.
REQ-009 iord, memtoreg, regdst, alusrca  out  1 each  datapath mux selects.
REQ-010 alusrcb  out  2  ALU B select: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-011 pcsrc  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 alucontrol  out  3  ALU operation.
REQ-013 illegal  out  1  unsupported opcode seen in DECODE.
REQ-014 state_o  out  4  current state encoding, for debug.

Function
REQ-015 The states SHALL be encoded as FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11; codes 12-15 SHALL go to FETCH next cycle with all outputs 0.
REQ-016 The opcodes SHALL be lw=100011, sw=101011, R=000000, beq=000100, addi=001000, j=000010.
REQ-017 FETCH SHALL hold while mem_ready=0, and SHALL go to DECODE when mem_ready=1.
REQ-018 DECODE SHALL branch on op: lw/sw to MEMADR, R to RTYPEEX, beq to BEQEX, addi to ADDIEX, j to JEX, any other value to FETCH.
REQ-019 MEMADR SHALL go to MEMRD on lw and to MEMWR on sw.
REQ-020 MEMRD and MEMWR SHALL hold while mem_ready=0; MEMRD SHALL then go to MEMWB and MEMWR to FETCH.
REQ-021 MEMWB, RTYPEWB, ADDIWB, BEQEX and JEX SHALL go to FETCH; RTYPEEX SHALL go to RTYPEWB; ADDIEX SHALL go to ADDIWB.
REQ-022 Outputs SHALL be combinational from state (plus mem_ready, zero, funct as listed), with every unlisted output 0.
- FETCH: alusrcb=01, irwrite=pcen=mem_ready.
- DECODE: alusrcb=11.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: iord=1, memwrite=1, held for the entire wait.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regwrite=1, regdst=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, pcen=zero.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcen=1.
REQ-023 alucontrol SHALL decode as follows.
- aluop 00 (internal): 010.
- aluop 01: 110.
- aluop 10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->000.
REQ-024 illegal SHALL be 1 only in DECODE with an unsupported op.
REQ-025 A single instruction SHALL never assert more than one of memwrite and regwrite in the same cycle.

Reset
REQ-026 While rst=0, state SHALL be FETCH asynchronously and pcen, irwrite, memwrite and regwrite SHALL be forced to 0.
REQ-027 After rst deasserts, the first rising edge with mem_ready=1 SHALL complete the fetch.
REQ-028 Reset asserted in any state, including mid-wait in MEMWR, SHALL drop memwrite in the same cycle without waiting for a clock.

Verification
REQ-029 lw sequence, mem_ready=1 always -> states 0,1,2,3,4,0 and regwrite=1, memtoreg=1 only in state 4.
REQ-030 sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH.
REQ-031 R-type, funct=101010 -> alucontrol=111 in RTYPEEX, regdst=1, regwrite=1 in RTYPEWB.
REQ-032 beq with zero=0, then beq with zero=1 -> pcen=0, then pcen=1 with pcsrc=01 in BEQEX.
REQ-033 op=111111 -> illegal=1 for one cycle in DECODE, then FETCH with no write enables asserted.
REQ-034 rst pulsed low mid-MEMWR -> memwrite=0 immediately, state_o=0, and a normal fetch follows release.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-style control unit: one FSM step per clock, with the
// datapath controls decoded combinationally from the current state.
module mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state;

  logic       pcen_dec;
  logic       irwrite_dec;
  logic       memwrite_dec;
  logic       regwrite_dec;
  logic [1:0] aluop;
  logic       bad_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= RTYPEEX;
            OP_BEQ:       state <= BEQEX;
            OP_ADDI:      state <= ADDIEX;
            OP_J:         state <= JEX;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: begin
          if (op == OP_LW)      state <= MEMRD;
          else if (op == OP_SW) state <= MEMWR;
          else                  state <= FETCH;
        end
        MEMRD:   if (mem_ready) state <= MEMWB;
        MEMWR:   if (mem_ready) state <= FETCH;
        RTYPEEX: state <= RTYPEWB;
        ADDIEX:  state <= ADDIWB;
        MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX: state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pcen_dec     = 1'b0;
    irwrite_dec  = 1'b0;
    memwrite_dec = 1'b0;
    regwrite_dec = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    illegal      = 1'b0;
    bad_state    = 1'b0;
    case (state)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_dec = mem_ready;
        pcen_dec    = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !(op == OP_LW || op == OP_SW || op == OP_R ||
                    op == OP_BEQ || op == OP_ADDI || op == OP_J);
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite_dec = 1'b1;
        memtoreg     = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_dec = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regwrite_dec = 1'b1;
        regdst       = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        pcen_dec = zero;
      end
      ADDIWB: regwrite_dec = 1'b1;
      JEX: begin
        pcsrc    = 2'b10;
        pcen_dec = 1'b1;
      end
      default: bad_state = 1'b1;
    endcase
  end

  // Unused encodings drive every output low, including the ALU operation.
  always_comb begin
    alucontrol = 3'b010;
    if (bad_state) begin
      alucontrol = 3'b000;
    end else if (aluop == 2'b01) begin
      alucontrol = 3'b110;
    end else if (aluop == 2'b10) begin
      case (funct)
        6'b100000: alucontrol = 3'b010;
        6'b100010: alucontrol = 3'b110;
        6'b100100: alucontrol = 3'b000;
        6'b100101: alucontrol = 3'b001;
        6'b101010: alucontrol = 3'b111;
        default:   alucontrol = 3'b000;
      endcase
    end
  end

  // Write enables are gated by reset directly so they drop without a clock edge.
  assign pcen     = pcen_dec & rst;
  assign irwrite  = irwrite_dec & rst;
  assign memwrite = memwrite_dec & rst;
  assign regwrite = regwrite_dec & rst;
  assign state_o  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: each instruction is expanded into its expected
// state walk and every cycle is compared against a per-state output table.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, irwrite, memwrite, regwrite;
  logic       iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state_o;

  int pass_count  = 0;
  int check_count = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite),
    .memwrite(memwrite), .regwrite(regwrite), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct { int st; bit mr; } step_t;

  function automatic bit is_legal(logic [5:0] o);
    return (o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == JMP);
  endfunction

  function automatic logic [2:0] rtype_alu(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // Packing: pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,
  // alusrcb[2],pcsrc[2],alucontrol[3],illegal
  function automatic logic [15:0] exp_out(int st, bit mr, bit z,
                                          logic [5:0] f, logic [5:0] o);
    logic pe = 0, iw = 0, mw = 0, rw = 0, io = 0, mt = 0, rd = 0, sa = 0, il = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] ac = 3'b010;
    case (st)
      0:  begin sb = 2'b01; iw = mr; pe = mr; end
      1:  begin sb = 2'b11; il = !is_legal(o); end
      2, 9: begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; mt = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; ac = rtype_alu(f); end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, iw, mw, rw, io, mt, rd, sa, sb, ps, ac, il};
  endfunction

  function automatic logic [15:0] observed();
    return {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
            alusrcb, pcsrc, alucontrol, illegal};
  endfunction

  task automatic check_output(string tag, int st, logic [15:0] expv);
    check_count++;
    assert (state_o === 4'(st)) pass_count++;
    else $error("FAIL %s state: observed %0d expected %0d", tag, state_o, st);
    check_count++;
    assert (observed() === expv) pass_count++;
    else $error("FAIL %s outputs: observed %b expected %b", tag, observed(), expv);
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic do_step(string tag, int st, bit mr, bit z);
    mem_ready = mr;
    zero      = z;
    #1;
    check_output(tag, st, exp_out(st, mr, z, funct, op));
    @(negedge clk);
  endtask

  task automatic run_instr(string tag, logic [5:0] o, logic [5:0] f, bit z,
                           int fetch_waits, int mem_waits);
    step_t q[$];
    op    = o;
    funct = f;
    for (int i = 0; i < fetch_waits; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom_range(0, 1))});
    if (o == LW || o == SW) begin
      q.push_back('{2, 1'($urandom_range(0, 1))});
      for (int i = 0; i < mem_waits; i++) q.push_back('{(o == LW) ? 3 : 5, 1'b0});
      q.push_back('{(o == LW) ? 3 : 5, 1'b1});
      if (o == LW) q.push_back('{4, 1'($urandom_range(0, 1))});
    end else if (o == RT) begin
      q.push_back('{6, 1'($urandom_range(0, 1))});
      q.push_back('{7, 1'($urandom_range(0, 1))});
    end else if (o == BEQ) begin
      q.push_back('{8, 1'($urandom_range(0, 1))});
    end else if (o == ADDI) begin
      q.push_back('{9, 1'($urandom_range(0, 1))});
      q.push_back('{10, 1'($urandom_range(0, 1))});
    end else if (o == JMP) begin
      q.push_back('{11, 1'($urandom_range(0, 1))});
    end
    foreach (q[i]) do_step(tag, q[i].st, q[i].mr, z);
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] functs [6];
    logic [5:0] rop;
    logic [15:0] rexp;
    ops    = '{LW, SW, RT, BEQ, ADDI, JMP};
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    rst = 1'b0; op = LW; funct = '0; zero = 1'b0; mem_ready = 1'b1;

    // Held in reset with mem_ready high: no fetch enables, state pinned.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      rexp = exp_out(0, 1'b1, 1'b0, funct, op);
      rexp[15:14] = 2'b00;
      check_output("reset", 0, rexp);
    end
    @(negedge clk);
    rst = 1'b1;

    run_instr("lw", LW, 6'b000000, 1'b0, 0, 0);
    run_instr("sw_wait3", SW, 6'b000000, 1'b0, 0, 3);
    run_instr("rtype_slt", RT, 6'b101010, 1'b0, 1, 0);
    run_instr("beq_z0", BEQ, 6'b000000, 1'b0, 0, 0);
    run_instr("beq_z1", BEQ, 6'b000000, 1'b1, 0, 0);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr("addi", ADDI, 6'b000000, 1'b0, 2, 0);
    run_instr("jump", JMP, 6'b000000, 1'b1, 0, 0);

    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 6);
      if (k == 6) begin
        do rop = 6'($urandom); while (is_legal(rop));
      end else begin
        rop = ops[k];
      end
      run_instr("random", rop, functs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset pulsed while a store is waiting on memory.
    op = SW;
    do_step("mid_sw", 0, 1'b1, 1'b0);
    do_step("mid_sw", 1, 1'b0, 1'b0);
    do_step("mid_sw", 2, 1'b0, 1'b0);
    do_step("mid_sw", 5, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    check_output("mid_sw_wait", 5, exp_out(5, 1'b0, 1'b0, funct, op));
    #1;
    rst = 1'b0;
    #1;
    check_output("mid_sw_reset", 0, exp_out(0, 1'b0, 1'b0, funct, op));
    @(negedge clk);
    rst = 1'b1;
    run_instr("post_reset_lw", LW, 6'b000000, 1'b0, 1, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
